// File: rtl/tlp_ocp_bridge.sv
// tlp_ocp_bridge
// Translates PCIe memory-request TLPs, received one DW per beat from an
// AXI-stream FIFO, into OCP 2.2 read and write commands.
//
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   m_axis_*           TLP stream in (tvalid/tready/tdata/tkeep/tlast)
//   cmd_accept         OCP SCmdAccept
//   address            OCP MAddr (byte address, bits[1:0] = 0)
//   enable             OCP command valid (read_request | write_request)
//   read_request       OCP RD command
//   write_request      OCP WR command
//   data_valid         write data valid (mirrors write_request)
//   write_data         OCP MData
//   byte_en            OCP MByteEn
//   burst_seq          burst sequence, always INCR
//   burst_single_req   1 on reads, 0 on writes
//   burst_length       TLP Length field (0 encodes 1024)
//   tlp_error          one-cycle pulse when a TLP is dropped or truncated
module tlp_ocp_bridge #(
    parameter int ADDR_WDTH = 64,
    parameter int MAX_LEN   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m_axis_tvalid,
    output logic                 m_axis_tready,
    input  logic [31:0]          m_axis_tdata,
    input  logic [3:0]           m_axis_tkeep,
    input  logic                 m_axis_tlast,
    input  logic                 cmd_accept,
    output logic [ADDR_WDTH-1:0] address,
    output logic                 enable,
    output logic                 read_request,
    output logic                 write_request,
    output logic                 data_valid,
    output logic [31:0]          write_data,
    output logic [3:0]           byte_en,
    output logic [2:0]           burst_seq,
    output logic                 burst_single_req,
    output logic [9:0]           burst_length,
    output logic                 tlp_error
);

    typedef enum logic [2:0] {
        HDR0, HDR1, HDR2, HDR3, RD_CMD, WR_DATA, DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic                   is_wr_q, is_wr_d;
    logic                   is4dw_q, is4dw_d;
    logic                   bad_q, bad_d;
    logic [9:0]             len_q, len_d;
    logic [3:0]             first_be_q, first_be_d;
    logic [3:0]             last_be_q, last_be_d;
    logic [31:0]            hi_q, hi_d;
    logic [ADDR_WDTH-1:0]   next_addr_q, next_addr_d;
    logic [10:0]            dw_left_q, dw_left_d;
    logic                   first_dw_q, first_dw_d;
    logic                   rd_drain_q, rd_drain_d;
    logic                   rd_req_q, rd_req_d;
    logic                   wr_req_q, wr_req_d;
    logic [ADDR_WDTH-1:0]   address_q, address_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             byte_en_q, byte_en_d;
    logic [9:0]             burst_len_q, burst_len_d;
    logic                   single_q, single_d;
    logic                   tlp_err_q, tlp_err_d;

    logic                   acc;
    logic                   hdr_done;
    logic                   wr_free;
    logic [10:0]            len_eff;
    logic [63:0]            hdr_addr64;
    logic [ADDR_WDTH-1:0]   hdr_addr;
    logic                   launch_rd;
    logic [ADDR_WDTH-1:0]   launch_addr;
    logic                   unused_keep;

    // tkeep carries no control meaning here.
    assign unused_keep = ^m_axis_tkeep;

    always_comb begin
        m_axis_tready = 1'b0;
        case (state_q)
            HDR0, HDR1, HDR2, HDR3, DRAIN: m_axis_tready = 1'b1;
            // A new data beat may enter when no write is pending or the
            // pending one is being accepted this cycle.
            WR_DATA: m_axis_tready = !wr_req_q || cmd_accept;
            default: m_axis_tready = 1'b0;
        endcase
        if (reset) m_axis_tready = 1'b0;
    end

    assign acc      = m_axis_tvalid && m_axis_tready;
    assign len_eff  = (m_axis_tdata[9:0] == 10'd0) ? 11'd1024 : {1'b0, m_axis_tdata[9:0]};
    assign hdr_done = acc && (((state_q == HDR2) && !is4dw_q) || (state_q == HDR3));
    assign wr_free  = !wr_req_q || cmd_accept;

    // The final header beat carries the low address word in either format.
    assign hdr_addr64 = is4dw_q ? {hi_q, m_axis_tdata[31:2], 2'b00}
                                : {32'd0, m_axis_tdata[31:2], 2'b00};
    assign hdr_addr   = hdr_addr64[ADDR_WDTH-1:0];

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        is4dw_d     = is4dw_q;
        bad_d       = bad_q;
        len_d       = len_q;
        first_be_d  = first_be_q;
        last_be_d   = last_be_q;
        hi_d        = hi_q;
        next_addr_d = next_addr_q;
        dw_left_d   = dw_left_q;
        first_dw_d  = first_dw_q;
        rd_drain_d  = rd_drain_q;
        rd_req_d    = rd_req_q;
        wr_req_d    = wr_req_q;
        address_d   = address_q;
        wdata_d     = wdata_q;
        byte_en_d   = byte_en_q;
        burst_len_d = burst_len_q;
        single_d    = single_q;
        tlp_err_d   = 1'b0;
        launch_rd   = 1'b0;
        launch_addr = next_addr_q;

        // Retire a pending write; a data beat below may replace it.
        if (wr_req_q && cmd_accept) wr_req_d = 1'b0;

        case (state_q)
            HDR0: if (acc) begin
                is_wr_d = m_axis_tdata[30];
                is4dw_d = m_axis_tdata[29];
                len_d   = m_axis_tdata[9:0];
                bad_d   = m_axis_tdata[31] || (m_axis_tdata[28:24] != 5'd0) ||
                          ({21'd0, len_eff} > 32'(MAX_LEN));
                if (m_axis_tlast) tlp_err_d = 1'b1;
                else              state_d   = HDR1;
            end
            HDR1: if (acc) begin
                first_be_d = m_axis_tdata[3:0];
                last_be_d  = m_axis_tdata[7:4];
                if (m_axis_tlast) begin
                    tlp_err_d = 1'b1;
                    state_d   = HDR0;
                end else begin
                    state_d = HDR2;
                end
            end
            HDR2: if (acc && is4dw_q) begin
                hi_d = m_axis_tdata;
                // A 32-bit OCP space cannot reach a nonzero upper word.
                if ((ADDR_WDTH == 32) && (m_axis_tdata != 32'd0)) bad_d = 1'b1;
                if (m_axis_tlast) begin
                    tlp_err_d = 1'b1;
                    state_d   = HDR0;
                end else begin
                    state_d = HDR3;
                end
            end
            RD_CMD: begin
                if (rd_req_q) begin
                    if (cmd_accept) begin
                        rd_req_d = 1'b0;
                        state_d  = rd_drain_q ? DRAIN : HDR0;
                    end
                end else if (wr_free) begin
                    // Read was deferred behind a previous TLP's last write.
                    launch_rd = 1'b1;
                end
            end
            WR_DATA: if (acc) begin
                wr_req_d    = 1'b1;
                address_d   = next_addr_q;
                next_addr_d = next_addr_q + ADDR_WDTH'(4);
                wdata_d     = m_axis_tdata;
                single_d    = 1'b0;
                burst_len_d = len_q;
                if (first_dw_q)               byte_en_d = first_be_q;
                else if (dw_left_q == 11'd1)  byte_en_d = last_be_q;
                else                          byte_en_d = 4'hF;
                first_dw_d = 1'b0;
                dw_left_d  = dw_left_q - 11'd1;
                if (dw_left_q == 11'd1) begin
                    tlp_err_d = !m_axis_tlast;
                    state_d   = m_axis_tlast ? HDR0 : DRAIN;
                end else if (m_axis_tlast) begin
                    tlp_err_d = 1'b1;
                    state_d   = HDR0;
                end
            end
            DRAIN: if (acc && m_axis_tlast) state_d = HDR0;
            default: state_d = HDR0;
        endcase

        if (hdr_done) begin
            if (bad_q) begin
                tlp_err_d = 1'b1;
                state_d   = m_axis_tlast ? HDR0 : DRAIN;
            end else if (!is_wr_q) begin
                next_addr_d = hdr_addr;
                launch_addr = hdr_addr;
                rd_drain_d  = !m_axis_tlast;
                tlp_err_d   = !m_axis_tlast;
                state_d     = RD_CMD;
                if (wr_free) launch_rd = 1'b1;
            end else if (m_axis_tlast) begin
                // Write header with no payload behind it.
                tlp_err_d = 1'b1;
                state_d   = HDR0;
            end else begin
                next_addr_d = hdr_addr;
                dw_left_d   = (len_q == 10'd0) ? 11'd1024 : {1'b0, len_q};
                first_dw_d  = 1'b1;
                state_d     = WR_DATA;
            end
        end

        if (launch_rd) begin
            rd_req_d    = 1'b1;
            address_d   = launch_addr;
            burst_len_d = len_q;
            single_d    = 1'b1;
            byte_en_d   = first_be_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HDR0;
            is_wr_q     <= 1'b0;
            is4dw_q     <= 1'b0;
            bad_q       <= 1'b0;
            len_q       <= '0;
            first_be_q  <= '0;
            last_be_q   <= '0;
            hi_q        <= '0;
            next_addr_q <= '0;
            dw_left_q   <= '0;
            first_dw_q  <= 1'b0;
            rd_drain_q  <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            address_q   <= '0;
            wdata_q     <= '0;
            byte_en_q   <= '0;
            burst_len_q <= '0;
            single_q    <= 1'b0;
            tlp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            is4dw_q     <= is4dw_d;
            bad_q       <= bad_d;
            len_q       <= len_d;
            first_be_q  <= first_be_d;
            last_be_q   <= last_be_d;
            hi_q        <= hi_d;
            next_addr_q <= next_addr_d;
            dw_left_q   <= dw_left_d;
            first_dw_q  <= first_dw_d;
            rd_drain_q  <= rd_drain_d;
            rd_req_q    <= rd_req_d;
            wr_req_q    <= wr_req_d;
            address_q   <= address_d;
            wdata_q     <= wdata_d;
            byte_en_q   <= byte_en_d;
            burst_len_q <= burst_len_d;
            single_q    <= single_d;
            tlp_err_q   <= tlp_err_d;
        end
    end

    assign address          = address_q;
    assign read_request     = rd_req_q;
    assign write_request    = wr_req_q;
    assign enable           = rd_req_q | wr_req_q;
    assign data_valid       = wr_req_q;
    assign write_data       = wdata_q;
    assign byte_en          = byte_en_q;
    assign burst_seq        = 3'b000;
    assign burst_single_req = single_q;
    assign burst_length     = burst_len_q;
    assign tlp_error        = tlp_err_q;

endmodule

// File: tb/tb_tlp_ocp_bridge.sv
// Directed bench for tlp_ocp_bridge: one instance at ADDR_WDTH=64/MAX_LEN=1024
// and one at ADDR_WDTH=32/MAX_LEN=16, selected onto a shared stream driver.
module tb_tlp_ocp_bridge;

    typedef struct packed {
        logic [63:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [9:0]  bl;
        logic        rd;
        logic        single;
    } cmd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = 4'hF;
    logic        cmd_accept = 1'b1;
    logic        sel = 1'b0;

    logic        a_tready, a_en, a_rd, a_wr, a_dv, a_single, a_err;
    logic [63:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_be;
    logic [2:0]  a_bseq;
    logic [9:0]  a_blen;
    logic        b_tready, b_en, b_rd, b_wr, b_dv, b_single, b_err;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_be;
    logic [2:0]  b_bseq;
    logic [9:0]  b_blen;

    tlp_ocp_bridge #(.ADDR_WDTH(64), .MAX_LEN(1024)) u_dut (
        .clk(clk), .reset(reset),
        .m_axis_tvalid(tvalid & ~sel), .m_axis_tready(a_tready),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
        .cmd_accept(cmd_accept), .address(a_addr), .enable(a_en),
        .read_request(a_rd), .write_request(a_wr), .data_valid(a_dv),
        .write_data(a_wdata), .byte_en(a_be), .burst_seq(a_bseq),
        .burst_single_req(a_single), .burst_length(a_blen), .tlp_error(a_err)
    );

    tlp_ocp_bridge #(.ADDR_WDTH(32), .MAX_LEN(16)) u_dut32 (
        .clk(clk), .reset(reset),
        .m_axis_tvalid(tvalid & sel), .m_axis_tready(b_tready),
        .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
        .cmd_accept(cmd_accept), .address(b_addr), .enable(b_en),
        .read_request(b_rd), .write_request(b_wr), .data_valid(b_dv),
        .write_data(b_wdata), .byte_en(b_be), .burst_seq(b_bseq),
        .burst_single_req(b_single), .burst_length(b_blen), .tlp_error(b_err)
    );

    wire        o_tready = sel ? b_tready : a_tready;
    wire        o_en     = sel ? b_en     : a_en;
    wire        o_rd     = sel ? b_rd     : a_rd;
    wire        o_wr     = sel ? b_wr     : a_wr;
    wire        o_dv     = sel ? b_dv     : a_dv;
    wire        o_single = sel ? b_single : a_single;
    wire        o_err    = sel ? b_err    : a_err;
    wire [63:0] o_addr   = sel ? {32'd0, b_addr} : a_addr;
    wire [31:0] o_wdata  = sel ? b_wdata  : a_wdata;
    wire [3:0]  o_be     = sel ? b_be     : a_be;
    wire [2:0]  o_bseq   = sel ? b_bseq   : a_bseq;
    wire [9:0]  o_blen   = sel ? b_blen   : a_blen;

    int n_chk = 0, n_pass = 0;
    int err_cnt = 0, inv_fail = 0, stab_fail = 0, rv_fail = 0, hold_cycles = 0;
    int acc_mode = 0, stall_cnt = 0, tot_stall = 0;
    logic data_phase = 1'b0;
    cmd_t q[$];
    cmd_t prev_snap;
    logic prev_hold = 1'b0;

    // OCP slave: always accepting, or holding each command 5 cycles.
    always @(posedge clk) begin
        #1;
        if (acc_mode == 0) begin
            cmd_accept = 1'b1;
        end else if (o_en && stall_cnt >= 5) begin
            cmd_accept = 1'b1;
            stall_cnt  = 0;
        end else begin
            cmd_accept = 1'b0;
            if (o_en) stall_cnt++;
        end
    end

    // Command capture and per-cycle invariants, sampled mid-cycle.
    always @(negedge clk) begin
        cmd_t snap;
        snap = {o_addr, (o_rd ? 32'd0 : o_wdata), o_be, o_blen, o_rd, o_single};
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (o_en && cmd_accept) q.push_back(snap);
            if (o_err) err_cnt++;
            if (o_en !== (o_rd | o_wr) || o_dv !== o_wr || o_bseq !== 3'b000 || (o_rd & o_wr))
                inv_fail++;
            if (prev_hold && snap !== prev_snap) stab_fail++;
            if (o_en && !cmd_accept) hold_cycles++;
            if (!sel && data_phase && o_wr && !cmd_accept && o_tready) rv_fail++;
            prev_hold = o_en && !cmd_accept;
            prev_snap = snap;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic expect_cmd(input string tag, input cmd_t e);
        cmd_t g;
        g = '1;
        if (q.size() > 0) g = q.pop_front();
        n_chk++;
        assert (g === e) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, g, e);
    endtask

    function automatic cmd_t mk(input logic [63:0] a, input logic [31:0] d,
                                input logic [3:0] be, input logic [9:0] bl, input logic rd);
        return {a, d, be, bl, rd, rd};
    endfunction

    task automatic beat(input logic [31:0] d, input logic last, output int stalls);
        logic r;
        tdata = d; tlast = last; tvalid = 1'b1; stalls = 0;
        forever begin
            @(negedge clk);
            r = o_tready;
            @(posedge clk);
            if (r) break;
            stalls++;
            if (stalls > 2000) begin
                n_chk++;
                $error("FAIL beat_timeout: observed no tready expected tready within 2000 cycles");
                break;
            end
        end
        tot_stall += stalls;
        #1;
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int s;
        beat(d, last, s);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (o_en && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            n_chk++;
            $error("FAIL idle_timeout: observed enable stuck expected idle");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s;
        int bad;
        cmd_t g, e;

        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("tready_in_reset", o_tready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("tready_after_reset", o_tready, 1);
        chk("ctrl_after_reset", {a_en, a_rd, a_wr, a_dv, a_single, a_err}, 0);
        chk("addr_after_reset", a_addr, 0);
        chk("data_after_reset", {a_wdata, a_be, a_blen}, 0);
        @(posedge clk);
        #1;

        // 4DW read, then a 3DW write straight behind it
        send(32'h2000000A, 1'b0);
        send(32'h000000FF, 1'b0);
        send(32'hEEEEEEEE, 1'b0);
        send(32'hFFFFFFFF, 1'b1);
        chk("rd_latency", o_rd, 1);
        beat(32'h40000004, 1'b0, s);
        chk("next_hdr_gap", s, 1);
        send(32'h00000081, 1'b0);
        send(32'h00001000, 1'b0);
        send(32'h11111111, 1'b0);
        send(32'h22222222, 1'b0);
        send(32'h33333333, 1'b0);
        send(32'h44444444, 1'b1);
        wait_idle();
        expect_cmd("rd4dw", mk(64'hEEEEEEEE_FFFFFFFC, 32'h0, 4'hF, 10'd10, 1'b1));
        expect_cmd("wr0", mk(64'h1000, 32'h11111111, 4'h1, 10'd4, 1'b0));
        expect_cmd("wr1", mk(64'h1004, 32'h22222222, 4'hF, 10'd4, 1'b0));
        expect_cmd("wr2", mk(64'h1008, 32'h33333333, 4'hF, 10'd4, 1'b0));
        expect_cmd("wr3", mk(64'h100C, 32'h44444444, 4'h8, 10'd4, 1'b0));
        chk("wr_no_error", err_cnt, 0);

        // Same write under 5-cycle command backpressure
        acc_mode = 1;
        hold_cycles = 0;
        send(32'h40000004, 1'b0);
        send(32'h00000081, 1'b0);
        send(32'h00002000, 1'b0);
        tot_stall = 0;
        data_phase = 1'b1;
        send(32'hA0A0A0A0, 1'b0);
        send(32'hA1A1A1A1, 1'b0);
        send(32'hA2A2A2A2, 1'b0);
        send(32'hA3A3A3A3, 1'b1);
        data_phase = 1'b0;
        chk("bp_stall_cycles", tot_stall, 15);
        wait_idle();
        acc_mode = 0;
        @(posedge clk);
        #1;
        chk("bp_hold_cycles", hold_cycles, 20);
        chk("bp_tready_low", rv_fail, 0);
        chk("bp_cmd_stable", stab_fail, 0);
        expect_cmd("bp_wr0", mk(64'h2000, 32'hA0A0A0A0, 4'h1, 10'd4, 1'b0));
        expect_cmd("bp_wr1", mk(64'h2004, 32'hA1A1A1A1, 4'hF, 10'd4, 1'b0));
        expect_cmd("bp_wr2", mk(64'h2008, 32'hA2A2A2A2, 4'hF, 10'd4, 1'b0));
        expect_cmd("bp_wr3", mk(64'h200C, 32'hA3A3A3A3, 4'h8, 10'd4, 1'b0));

        // Config-type TLP dropped, then a 3DW read
        send(32'h04000001, 1'b0);
        send(32'h0000000F, 1'b0);
        send(32'h00000100, 1'b0);
        send(32'h12345678, 1'b1);
        wait_idle();
        chk("cfg_no_cmd", q.size(), 0);
        chk("cfg_error", err_cnt, 1);
        send(32'h00000002, 1'b0);
        send(32'h000000F3, 1'b0);
        send(32'h0000ABC4, 1'b1);
        wait_idle();
        expect_cmd("rd3dw", mk(64'hABC4, 32'h0, 4'h3, 10'd2, 1'b1));

        // tlast inside the header
        send(32'h40000004, 1'b0);
        send(32'h000000FF, 1'b1);
        wait_idle();
        chk("hdr_abort_no_cmd", q.size(), 0);
        chk("hdr_abort_error", err_cnt, 2);

        // Length=4 write truncated after 2 data beats
        send(32'h40000004, 1'b0);
        send(32'h000000FF, 1'b0);
        send(32'h00003000, 1'b0);
        send(32'h55555555, 1'b0);
        send(32'h66666666, 1'b1);
        wait_idle();
        expect_cmd("trunc_wr0", mk(64'h3000, 32'h55555555, 4'hF, 10'd4, 1'b0));
        expect_cmd("trunc_wr1", mk(64'h3004, 32'h66666666, 4'hF, 10'd4, 1'b0));
        chk("trunc_error", err_cnt, 3);

        // Read header without tlast: read issued, extra beat drained
        send(32'h00000001, 1'b0);
        send(32'h0000000F, 1'b0);
        send(32'h00005008, 1'b0);
        send(32'hDEADBEEF, 1'b1);
        wait_idle();
        expect_cmd("rd_nolast", mk(64'h5008, 32'h0, 4'hF, 10'd1, 1'b1));
        chk("rd_nolast_error", err_cnt, 4);
        chk("rd_nolast_no_extra", q.size(), 0);

        // Length=0 write: 1024 data beats
        send(32'h40000000, 1'b0);
        send(32'h000000C3, 1'b0);
        send(32'h00010000, 1'b0);
        for (int i = 0; i < 1024; i++) send(32'hC0DE0000 + 32'(i), (i == 1023));
        wait_idle();
        chk("len0_count", q.size(), 1024);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            e = mk(64'h10000 + 64'(4 * i), 32'hC0DE0000 + 32'(i),
                   (i == 0) ? 4'h3 : ((i == 1023) ? 4'hC : 4'hF), 10'd0, 1'b0);
            g = '1;
            if (q.size() > 0) g = q.pop_front();
            if (g !== e) bad++;
        end
        chk("len0_write_seq", bad, 0);
        chk("len0_no_error", err_cnt, 4);

        // 32-bit / MAX_LEN=16 instance
        sel = 1'b1;
        @(posedge clk);
        #1;
        send(32'h60000001, 1'b0);
        send(32'h0000000F, 1'b0);
        send(32'h00000001, 1'b0);
        send(32'h00004000, 1'b0);
        send(32'h77777777, 1'b1);
        wait_idle();
        chk("a32_hi_no_cmd", q.size(), 0);
        chk("a32_hi_error", err_cnt, 5);
        send(32'h40000000, 1'b0);
        send(32'h0000000F, 1'b0);
        send(32'h00006000, 1'b0);
        send(32'h00000001, 1'b0);
        send(32'h00000002, 1'b0);
        send(32'h00000003, 1'b1);
        wait_idle();
        chk("maxlen_no_cmd", q.size(), 0);
        chk("maxlen_error", err_cnt, 6);
        send(32'h20000001, 1'b0);
        send(32'h0000000F, 1'b0);
        send(32'h00000000, 1'b0);
        send(32'h1234567B, 1'b1);
        wait_idle();
        expect_cmd("a32_rd", mk(64'h12345678, 32'h0, 4'hF, 10'd1, 1'b1));
        chk("a32_rd_no_error", err_cnt, 6);
        chk("output_invariants", inv_fail, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed time limit expected completion");
        $fatal(1, "timeout");
    end

endmodule
